// File: rtl/mod3_link_pkg.sv
// Shared definitions for the mod-3 ones-count serial link: state encodings,
// residue constants and the check-bit mapping used by transmitter and checker.
package mod3_link_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CHK0 = 2'd2,
        S_CHK1 = 2'd3
    } state_t;

    localparam logic [1:0] R0 = 2'd0;
    localparam logic [1:0] R1 = 2'd1;
    localparam logic [1:0] R2 = 2'd2;

    // Two trailing bits that bring the frame's ones count up to a multiple of 3;
    // bit [1] is sent first.
    function automatic logic [1:0] chk_bits(input logic [1:0] r);
        chk_bits = {(r != R0), (r == R1)};
    endfunction

endpackage

// File: rtl/mod3_frame_tx_if.sv
// Word-source / serial-line bundle for the mod-3 frame transmitter.
interface mod3_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              load;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              ser_out;
    logic              ser_valid;
    logic              frame_last;

    modport master (
        output load, data_in,
        input  ready, ser_out, ser_valid, frame_last
    );

    modport slave (
        input  load, data_in,
        output ready, ser_out, ser_valid, frame_last
    );
endinterface

// File: rtl/mod3_acc.sv
// Running count of 1s modulo 3 over a qualified bit stream; clr has priority over en.
module mod3_acc
    import mod3_link_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [1:0] residue
);

    logic [1:0] residue_q;
    logic [1:0] residue_d;

    always_comb begin
        residue_d = residue_q;
        if (clr) begin
            residue_d = R0;
        end else if (en && bit_in) begin
            case (residue_q)
                R0:      residue_d = R1;
                R1:      residue_d = R2;
                default: residue_d = R0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            residue_q <= R0;
        end else begin
            residue_q <= residue_d;
        end
    end

    assign residue = residue_q;

endmodule

// File: rtl/mod3_frame_tx.sv
// Serialises a DATA_W-bit word MSB first and appends two check bits so every
// frame carries a multiple of three 1s.
module mod3_frame_tx
    import mod3_link_pkg::*;
#(
    parameter int DATA_W = 8
)(
    input  logic clk,
    input  logic reset,
    mod3_frame_tx_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state_q,  state_d;
    logic [DATA_W-1:0] shreg_q,  shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    logic       accept;
    logic [1:0] residue;
    logic [1:0] chk;
    logic       ready, ser_out, ser_valid, frame_last;

    // Only data bits feed the residue; it is cleared as a word is accepted.
    mod3_acc u_acc (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     (state_q == S_DATA),
        .bit_in (shreg_q[DATA_W-1]),
        .residue(residue)
    );

    assign chk = chk_bits(residue);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        accept     = 1'b0;
        ready      = 1'b0;
        ser_out    = 1'b0;
        ser_valid  = 1'b0;
        frame_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.load) begin
                    accept    = 1'b1;
                    shreg_d   = bus.data_in;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                ser_valid = 1'b1;
                ser_out   = shreg_q[DATA_W-1];
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = S_CHK0;
                end
            end
            S_CHK0: begin
                ser_valid = 1'b1;
                ser_out   = chk[1];
                state_d   = S_CHK1;
            end
            S_CHK1: begin
                ser_valid  = 1'b1;
                ser_out    = chk[0];
                frame_last = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bus.ready      = ready;
    assign bus.ser_out    = ser_out;
    assign bus.ser_valid  = ser_valid;
    assign bus.frame_last = frame_last;

endmodule

// File: tb/tb_mod3_frame_tx.sv
// Bench for mod3_frame_tx at DATA_W=8 and DATA_W=13: directed frames, load
// hammering, mid-frame reset and random words against a ones-count frame model.
module tb_mod3_frame_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mod3_frame_tx_if #(.DATA_W(8))  b8();
    mod3_frame_tx_if #(.DATA_W(13)) b13();

    mod3_frame_tx #(.DATA_W(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));
    mod3_frame_tx #(.DATA_W(13)) dut13 (.clk(clk), .reset(reset), .bus(b13.slave));

    int n_cmp = 0;
    int n_bad = 0;
    logic sel = 1'b0;   // 0 -> 8-bit DUT, 1 -> 13-bit DUT

    wire o_ready = sel ? b13.ready      : b8.ready;
    wire o_ser   = sel ? b13.ser_out    : b8.ser_out;
    wire o_valid = sel ? b13.ser_valid  : b8.ser_valid;
    wire o_last  = sel ? b13.frame_last : b8.frame_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_load(input logic v, input logic [31:0] d);
        if (sel) begin
            b13.load    = v;
            b13.data_in = d[12:0];
        end else begin
            b8.load    = v;
            b8.data_in = d[7:0];
        end
    endtask

    // Sends one word and checks the whole frame bit by bit plus the idle cycle
    // after it. With hold set, load stays high with fresh random data throughout.
    task automatic send_frame(input logic [31:0] data, input bit hold);
        int w;
        int t;
        int ones;
        int r;
        logic [31:0] d;
        logic [1:0] cb;
        logic exp_bit;
        w = sel ? 13 : 8;
        d = data & ((32'd1 << w) - 1);
        r = $countones(d) % 3;
        cb = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : 2'b10;
        t = 0;
        while (!o_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("ready_wait", o_ready, 1'b1);
        set_load(1'b1, d);
        @(negedge clk);
        if (hold) set_load(1'b1, $urandom);
        else      set_load(1'b0, 32'd0);
        ones = 0;
        for (int i = 0; i < w + 2; i++) begin
            exp_bit = (i < w) ? d[w-1-i] : ((i == w) ? cb[1] : cb[0]);
            check_eq("valid", o_valid, 1'b1);
            check_eq("ready_busy", o_ready, 1'b0);
            check_eq("ser_out", o_ser, exp_bit);
            check_eq("frame_last", o_last, (i == w + 1));
            if (o_ser === 1'b1) ones++;
            if (i == w + 1) check_eq("detector", ((ones % 3) == 0), 1'b1);
            @(negedge clk);
            if (hold) set_load(1'b1, $urandom);
        end
        check_eq("gap_valid", o_valid, 1'b0);
        check_eq("gap_ready", o_ready, 1'b1);
        $display("frame w=%0d data=%0h ones=%0d chk=%b", w, d, ones, cb);
    endtask

    initial begin
        b8.load = 1'b0;  b8.data_in = '0;
        b13.load = 1'b0; b13.data_in = '0;
        reset = 1'b1;
        #1;
        check_eq("rst_ready", b8.ready, 1'b1);
        check_eq("rst_valid", b8.ser_valid, 1'b0);
        check_eq("rst_ser", b8.ser_out, 1'b0);
        check_eq("rst_last", b8.frame_last, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        sel = 1'b0;
        send_frame(32'hFF, 1'b0);
        send_frame(32'h00, 1'b0);
        send_frame(32'h01, 1'b0);
        send_frame(32'hA1, 1'b0);

        // load held high: only words presented while ready=1 go out
        for (int k = 0; k < 3; k++) send_frame($urandom, 1'b1);
        set_load(1'b0, 32'd0);
        @(negedge clk);

        // reset on the 4th data bit of an 8'hFF frame
        set_load(1'b1, 32'hFF);
        @(negedge clk);
        set_load(1'b0, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("pre_rst_valid", o_valid, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("abort_valid", o_valid, 1'b0);
        check_eq("abort_ready", o_ready, 1'b1);
        check_eq("abort_last", o_last, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_valid", o_valid, 1'b0);
        send_frame(32'h07, 1'b0);

        for (int k = 0; k < 250; k++) send_frame($urandom, 1'b0);
        sel = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 250; k++) send_frame($urandom, 1'b0);
        send_frame(32'h1FFF, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
